// File: rtl/sincos_seq_ctrl.sv
// sincos_seq_ctrl: shadow/active tone config with commit, resync and lock sequencing.
// Optional macro SINCOS_SEQ_AUTO_RECOVER_EN enables bounded automatic resync retries.
module sincos_seq_ctrl #(
  parameter int FREQ_NUM   = 5,
  parameter int PCMAW      = 11,
  parameter int RESYNC_CYC = 8,
  parameter int TIMEOUT    = 4096,
  parameter int MAX_RETRY  = 3
) (
  input  logic                   da_clk,
  input  logic                   rst,
  input  logic                   cfg_wr,
  input  logic [3:0]             cfg_addr,
  input  logic [15:0]            cfg_wdata,
  input  logic                   cfg_commit,
  output logic [16*FREQ_NUM-1:0] sc_sin_length,
  output logic [4*FREQ_NUM-1:0]  sc_cic_rate,
  output logic                   sc_resync,
  input  logic                   sc_iqpcm_valid,
  input  logic                   sc_err,
  output logic                   busy,
  output logic                   locked,
  output logic                   failed,
  output logic                   cfg_reject,
  output logic [1:0]             retry_cnt
);

`ifdef SINCOS_SEQ_AUTO_RECOVER_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  localparam int LW   = PCMAW + 1;
  localparam int CMAX = (TIMEOUT > RESYNC_CYC) ? TIMEOUT : RESYNC_CYC;
  localparam int CW   = $clog2(CMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESYNC,
    S_WAIT,
    S_RUN,
    S_RECOVER,
    S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    retry_q, retry_d;
  logic          pend_q, pend_d;
  logic          rej_q, rej_d;
  logic          commit_req;
  logic          accept;
  logic          shadow_ok;

  logic [LW-1:0] sh_len_q   [FREQ_NUM];
  logic [3:0]    sh_rate_q  [FREQ_NUM];
  logic [LW-1:0] act_len_q  [FREQ_NUM];
  logic [3:0]    act_rate_q [FREQ_NUM];

  logic [2:0] wr_idx;
  logic [3:0] wr_rate;
  logic       unused_wdata;

  assign wr_idx       = cfg_addr[3:1];
  assign wr_rate      = (cfg_wdata[3:0] > 4'd12) ? 4'd12 : cfg_wdata[3:0];
  assign unused_wdata = ^cfg_wdata[15:LW];

  // Shadow writes; tone indices beyond FREQ_NUM match no slot
  always_ff @(posedge da_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FREQ_NUM; i++) begin
        sh_len_q[i]  <= '0;
        sh_rate_q[i] <= '0;
      end
    end else if (cfg_wr) begin
      for (int i = 0; i < FREQ_NUM; i++) begin
        if (int'(wr_idx) == i) begin
          if (cfg_addr[0]) sh_rate_q[i] <= wr_rate;
          else             sh_len_q[i]  <= cfg_wdata[LW-1:0];
        end
      end
    end
  end

  // Active copy is loaded from shadow only on an accepted commit
  always_ff @(posedge da_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FREQ_NUM; i++) begin
        act_len_q[i]  <= '0;
        act_rate_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < FREQ_NUM; i++) begin
        act_len_q[i]  <= sh_len_q[i];
        act_rate_q[i] <= sh_rate_q[i];
      end
    end
  end

  for (genvar g = 0; g < FREQ_NUM; g++) begin : g_out
    assign sc_sin_length[16*g +: 16] = 16'(act_len_q[g]);
    assign sc_cic_rate[4*g +: 4]     = act_rate_q[g];
  end

  // A commit is only legal when every tone has a non-zero length
  always_comb begin
    shadow_ok = 1'b1;
    for (int i = 0; i < FREQ_NUM; i++) begin
      if (sh_len_q[i] == '0) shadow_ok = 1'b0;
    end
  end

  // Sequencer state and counters
  always_ff @(posedge da_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      pend_q  <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      pend_q  <= pend_d;
      rej_q   <= rej_d;
    end
  end

  // Next state: commits while busy are deferred until RUN or FAIL
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    pend_d     = pend_q;
    commit_req = 1'b0;
    unique case (state_q)
      S_IDLE: commit_req = cfg_commit;
      S_RUN, S_FAIL: begin
        commit_req = cfg_commit | pend_q;
        pend_d     = 1'b0;
      end
      default: pend_d = pend_q | cfg_commit;
    endcase
    accept = commit_req & shadow_ok;
    rej_d  = commit_req & ~shadow_ok;
    if (accept) begin
      retry_d = '0;
      cnt_d   = '0;
      state_d = S_RESYNC;
    end else begin
      unique case (state_q)
        S_RESYNC: begin
          if (cnt_q == CW'(RESYNC_CYC - 1)) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (sc_iqpcm_valid) begin
            state_d = S_RUN;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = S_RECOVER;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (sc_err || !sc_iqpcm_valid) state_d = S_RECOVER;
        end
        S_RECOVER: begin
          if (AUTO_EN && (int'(retry_q) < MAX_RETRY)) begin
            retry_d = retry_q + 2'd1;
            cnt_d   = '0;
            state_d = S_RESYNC;
          end else begin
            state_d = S_FAIL;
          end
        end
        default: ;
      endcase
    end
  end

  assign sc_resync  = (state_q == S_RESYNC);
  assign busy       = (state_q == S_RESYNC) || (state_q == S_WAIT) ||
                      (state_q == S_RECOVER);
  assign locked     = (state_q == S_RUN);
  assign failed     = (state_q == S_FAIL);
  assign cfg_reject = rej_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_sincos_seq_ctrl.sv
// tb_sincos_seq_ctrl: randomized scenarios checked against a register/rule model.
// Build with SINCOS_SEQ_AUTO_RECOVER_EN to check the auto-retry variant.
module tb_sincos_seq_ctrl;
  localparam int FN = 5;
  localparam int PCMAW = 11;
  localparam int RC = 8;
  localparam int TO = 4096;
  localparam int MR = 3;
`ifdef SINCOS_SEQ_AUTO_RECOVER_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          da_clk;
  logic          rst;
  logic          cfg_wr;
  logic [3:0]    cfg_addr;
  logic [15:0]   cfg_wdata;
  logic          cfg_commit;
  logic [16*FN-1:0] sc_sin_length;
  logic [4*FN-1:0]  sc_cic_rate;
  logic          sc_resync;
  logic          sc_iqpcm_valid;
  logic          sc_err;
  logic          busy;
  logic          locked;
  logic          failed;
  logic          cfg_reject;
  logic [1:0]    retry_cnt;

  sincos_seq_ctrl #(
    .FREQ_NUM(FN), .PCMAW(PCMAW), .RESYNC_CYC(RC),
    .TIMEOUT(TO), .MAX_RETRY(MR)
  ) dut (
    .da_clk(da_clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .sc_sin_length(sc_sin_length), .sc_cic_rate(sc_cic_rate),
    .sc_resync(sc_resync), .sc_iqpcm_valid(sc_iqpcm_valid),
    .sc_err(sc_err), .busy(busy), .locked(locked), .failed(failed),
    .cfg_reject(cfg_reject), .retry_cnt(retry_cnt)
  );

  initial da_clk = 1'b0;
  always #5 da_clk = ~da_clk;

  int n_chk = 0;
  int n_pass = 0;
  int sh_len[FN];
  int sh_rate[FN];
  int act_len[FN];
  int act_rate[FN];
  int m_retry;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge da_clk);
    #1;
  endtask

  function automatic int rand_len();
    return $urandom_range(1, 4095) | ($urandom_range(0, 15) << 12);
  endfunction

  function automatic bit shadow_valid();
    for (int i = 0; i < FN; i++) if (sh_len[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_wr(input bit fld, input int idx, input int data);
    int r;
    if (idx < FN) begin
      if (fld) begin
        r = data % 16;
        sh_rate[idx] = (r > 12) ? 12 : r;
      end else begin
        sh_len[idx] = data % (1 << (PCMAW + 1));
      end
    end
  endtask

  task automatic model_apply();
    for (int i = 0; i < FN; i++) begin
      act_len[i]  = sh_len[i];
      act_rate[i] = sh_rate[i];
    end
    m_retry = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < FN; i++) begin
      sh_len[i] = 0; sh_rate[i] = 0; act_len[i] = 0; act_rate[i] = 0;
    end
    m_retry = 0;
  endtask

  task automatic wr(input bit fld, input int idx, input int data);
    cfg_wr = 1'b1;
    cfg_addr = {3'(idx), fld};
    cfg_wdata = 16'(data);
    tick();
    cfg_wr = 1'b0;
    model_wr(fld, idx, data);
  endtask

  task automatic check_act(input string tag);
    for (int i = 0; i < FN; i++) begin
      check($sformatf("%s_len%0d", tag, i),
            32'(sc_sin_length[16*i +: 16]), act_len[i]);
      check($sformatf("%s_rate%0d", tag, i),
            32'(sc_cic_rate[4*i +: 4]), act_rate[i]);
    end
  endtask

  // commit issued from a non-busy state: accepted or refused immediately
  task automatic commit_now(input string tag);
    bit ok;
    ok = shadow_valid();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    if (ok) model_apply();
    check({tag, "_resync"}, sc_resync, ok);
    check({tag, "_reject"}, cfg_reject, !ok);
    check({tag, "_retry"}, retry_cnt, m_retry);
    check_act(tag);
  endtask

  task automatic count_resync(output int n);
    n = 0;
    while (sc_resync === 1'b1 && n < RC + 50) begin
      n++;
      tick();
    end
  endtask

  task automatic count_gap(output int n);
    n = 0;
    while (busy === 1'b1 && sc_resync !== 1'b1 && n < TO + 50) begin
      n++;
      tick();
    end
  endtask

  // sampled on the cycle after RECOVER
  task automatic recover_rule(input string tag);
    bit exp_fail;
    if (AUTO && m_retry < MR) begin
      m_retry++;
      exp_fail = 1'b0;
    end else begin
      exp_fail = 1'b1;
    end
    check({tag, "_failed"}, failed, exp_fail);
    check({tag, "_resync"}, sc_resync, !exp_fail);
    check({tag, "_retry"}, retry_cnt, m_retry);
  endtask

  task automatic timeout_ep(input string tag);
    int n;
    count_resync(n);
    check({tag, "_rs_len"}, n, RC);
    count_gap(n);
    check({tag, "_wait_len"}, n, TO + 1);
    recover_rule(tag);
  endtask

  initial begin
    int n;
    int ep;
    int k;
    int snap_len[FN];
    int snap_rate[FN];
    rst = 1'b1;
    cfg_wr = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    cfg_commit = 1'b0;
    sc_iqpcm_valid = 1'b0;
    sc_err = 1'b0;
    model_clear();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_locked", locked, 0);
    check("rst_busy", busy, 0);
    check("rst_failed", failed, 0);
    check("rst_resync", sc_resync, 0);
    check("rst_reject", cfg_reject, 0);
    check("rst_retry", retry_cnt, 0);
    check_act("rst");

    wr(0, 0, rand_len());
    commit_now("rej_idle");
    tick();
    check("rej_pulse_end", cfg_reject, 0);
    check("rej_idle_state", {busy, locked, failed}, 0);

    wr(0, 0, 1024);
    wr(1, 0, 3);
    for (int i = 1; i < FN; i++) begin
      wr(0, i, 512);
      wr(1, i, 2);
    end
    wr(1, 1, $urandom_range(13, 15));
    wr(0, 7, rand_len());
    wr(1, 7, $urandom_range(0, 15));
    commit_now("plan");
    check("plan_len0", 32'(sc_sin_length[15:0]), 1024);
    check("plan_clamp", 32'(sc_cic_rate[7:4]), 12);
    count_resync(n);
    check("plan_rs_len", n, RC);
    repeat (100) tick();
    check("plan_wait_busy", busy, 1);
    check("plan_wait_lock", locked, 0);
    sc_iqpcm_valid = 1'b1;
    tick();
    check("plan_locked", locked, 1);

    sc_err = 1'b1;
    tick();
    sc_err = 1'b0;
    check("err_recover_busy", busy, 1);
    check("err_recover_lock", locked, 0);
    tick();
    recover_rule("err");
    if (AUTO) begin
      count_resync(n);
      check("err_rs_len", n, RC);
      tick();
      check("err_relock", locked, 1);
    end
    for (int i = 0; i < FN; i++) begin
      wr(0, i, rand_len());
      wr(1, i, $urandom_range(0, 15));
    end
    commit_now("recommit");
    count_resync(n);
    check("recommit_rs_len", n, RC);
    tick();
    check("recommit_locked", locked, 1);

    for (int i = 0; i < FN; i++) begin
      snap_len[i] = sh_len[i];
      snap_rate[i] = sh_rate[i];
    end
    k = $urandom_range(0, FN - 1);
    cfg_wr = 1'b1;
    cfg_addr = {3'(k), 1'b0};
    cfg_wdata = 16'(rand_len());
    cfg_commit = 1'b1;
    tick();
    cfg_wr = 1'b0;
    cfg_commit = 1'b0;
    for (int i = 0; i < FN; i++) begin
      act_len[i] = snap_len[i];
      act_rate[i] = snap_rate[i];
    end
    m_retry = 0;
    model_wr(1'b0, k, int'(cfg_wdata));
    check("simul_resync", sc_resync, 1);
    check_act("simul");
    count_resync(n);
    check("simul_rs_len", n, RC);
    tick();
    check("simul_locked", locked, 1);

    commit_now("pend_c0");
    sc_iqpcm_valid = 1'b0;
    count_resync(n);
    check("pend_rs0_len", n, RC);
    repeat ($urandom_range(5, 50)) tick();
    for (int i = 0; i < FN; i++) wr(0, i, 256);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("pend_reject", cfg_reject, 0);
    check_act("pend_hold");
    tick();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("pend_busy", busy, 1);
    sc_iqpcm_valid = 1'b1;
    tick();
    check("pend_run", locked, 1);
    check_act("pend_run_old");
    tick();
    model_apply();
    check("pend_resync", sc_resync, 1);
    check_act("pend_new");
    count_resync(n);
    check("pend_rs1_len", n, RC);
    tick();
    repeat (RC + 4) tick();
    check("pend_merged", locked, 1);

    sc_iqpcm_valid = 1'b0;
    tick();
    check("fall_recover", busy, 1);
    tick();
    recover_rule("fall");
    ep = 0;
    while (failed !== 1'b1 && ep < MR + 3) begin
      timeout_ep($sformatf("fall_to%0d", ep));
      ep++;
    end
    check("fall_eps", ep, AUTO ? MR : 0);
    check("fall_failed", failed, 1);

    commit_now("to_commit");
    ep = 0;
    while (failed !== 1'b1 && ep < MR + 3) begin
      timeout_ep($sformatf("to%0d", ep));
      ep++;
    end
    check("to_eps", ep, AUTO ? MR + 1 : 1);
    check("to_failed", failed, 1);
    check("to_retry", retry_cnt, AUTO ? MR : 0);

    wr(0, 3, 0);
    commit_now("fail_rej");
    tick();
    check("fail_rej_hold", failed, 1);

    wr(0, 3, rand_len());
    commit_now("rstmid");
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check("rstmid_resync", sc_resync, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_failed", failed, 0);
    check_act("rstmid");
    #1;
    rst = 1'b0;
    tick();
    check("rstmid_idle", {busy, locked, failed}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
